tim_time_base: RTL and testbench

TIM_TIME_BASE -- requirements
Module: tim_time_base

---
 rtl/tim_time_base.sv | 173 +++++++++++++++++
 tb/tb_tim_time_base.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tim_time_base.sv
`default_nettype none
// tim_time_base: prescaled edge/center-aligned timer time base producing update events.
// Optional one-pulse mode (stop latch, cen_clr_o) is built when TIM_OPM_EN is defined.
module tim_time_base #(
  parameter int CNT_WIDTH = 32,
  parameter int PSC_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 aresetn_i,
  input  logic                 cen_i,
  input  logic                 udis_i,
  input  logic                 urs_i,
  input  logic                 arpe_i,
  input  logic                 dir_cfg_i,
  input  logic [1:0]           cms_i,
  input  logic                 opm_i,
  input  logic [PSC_WIDTH-1:0] psc_i,
  input  logic [CNT_WIDTH-1:0] arr_i,
  input  logic                 ug_i,
  input  logic                 cnt_wr_i,
  input  logic [CNT_WIDTH-1:0] cnt_wdata_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 dir_o,
  output logic                 uev_o,
  output logic                 uif_set_o,
  output logic                 cen_clr_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [PSC_WIDTH-1:0] psc_cnt_q, psc_cnt_d;
  logic [PSC_WIDTH-1:0] psc_sh_q, psc_sh_d;
  logic [CNT_WIDTH-1:0] arr_sh_q, arr_sh_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 dir_q, dir_d;
  logic                 uev_q, uev_d;
  logic                 uif_q, uif_d;
  logic                 cen_clr_q, cen_clr_d;
  logic                 stop_q, stop_d;
  logic                 ld_done_q;

  logic [PSC_WIDTH-1:0] psc_lim;
  logic [CNT_WIDTH-1:0] arr_lim;
  logic                 edge_mode;
  logic                 run;
  logic                 tick;
  logic                 wrap;
  logic                 ev_wrap;

  // Until the first cycle after reset has loaded the shadows, compare against the
  // live inputs so the first tick lands psc_i+1 enabled cycles after release.
  always_comb begin
    psc_lim   = ld_done_q ? psc_sh_q : psc_i;
    arr_lim   = ld_done_q ? arr_sh_q : arr_i;
    edge_mode = (cms_i == 2'b00);
    run       = cen_i & ~stop_q;
    tick      = run & (psc_cnt_q == psc_lim);
  end

  always_comb begin
    psc_cnt_d = psc_cnt_q;
    cnt_d     = cnt_q;
    dir_d     = edge_mode ? dir_cfg_i : dir_q;
    wrap      = 1'b0;

    if (run) begin
      psc_cnt_d = tick ? '0 : psc_cnt_q + PSC_WIDTH'(1);
    end

    if (ug_i) begin
      psc_cnt_d = '0;
      if (edge_mode && dir_cfg_i) begin
        cnt_d = arr_i;
      end else begin
        cnt_d = '0;
        dir_d = 1'b0;
      end
    end else if (cnt_wr_i) begin
      cnt_d = cnt_wdata_i;
    end else if (tick) begin
      if (arr_lim == '0) begin
        cnt_d = '0;
        wrap  = 1'b1;
      end else if (edge_mode) begin
        if (!dir_cfg_i) begin
          // A written value above the limit runs on to the natural wrap.
          if (cnt_q == arr_lim || cnt_q == CNT_MAX) begin
            cnt_d = '0;
            wrap  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end else begin
          if (cnt_q == '0) begin
            cnt_d = arr_lim;
            wrap  = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
          end
        end
      end else if (!dir_q) begin
        if (cnt_q == arr_lim || cnt_q == CNT_MAX) begin
          cnt_d = arr_lim - CNT_WIDTH'(1);
          dir_d = 1'b1;
          wrap  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end else begin
        if (cnt_q == '0) begin
          cnt_d = CNT_WIDTH'(1);
          dir_d = 1'b0;
          wrap  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
    end

    ev_wrap  = wrap & ~udis_i;
    uev_d    = ug_i | ev_wrap;
    uif_d    = (ug_i & ~urs_i) | ev_wrap;
    psc_sh_d = (uev_d || !ld_done_q) ? psc_i : psc_sh_q;
    arr_sh_d = (uev_d || !ld_done_q || !arpe_i) ? arr_i : arr_sh_q;

`ifdef TIM_OPM_EN
    cen_clr_d = wrap & opm_i;
    stop_d    = cen_i ? (stop_q | (wrap & opm_i)) : 1'b0;
`else
    cen_clr_d = 1'b0;
    stop_d    = 1'b0;
`endif
  end

`ifndef TIM_OPM_EN
  logic opm_unused;
  assign opm_unused = opm_i;
`endif

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      psc_cnt_q <= '0;
      psc_sh_q  <= '0;
      arr_sh_q  <= '0;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      uev_q     <= 1'b0;
      uif_q     <= 1'b0;
      cen_clr_q <= 1'b0;
      stop_q    <= 1'b0;
      ld_done_q <= 1'b0;
    end else begin
      psc_cnt_q <= psc_cnt_d;
      psc_sh_q  <= psc_sh_d;
      arr_sh_q  <= arr_sh_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      uev_q     <= uev_d;
      uif_q     <= uif_d;
      cen_clr_q <= cen_clr_d;
      stop_q    <= stop_d;
      ld_done_q <= 1'b1;
    end
  end

  assign cnt_o     = cnt_q;
  assign dir_o     = dir_q;
  assign uev_o     = uev_q;
  assign uif_set_o = uif_q;
  assign cen_clr_o = cen_clr_q;

endmodule
`default_nettype wire

// File: tb/tb_tim_time_base.sv
`default_nettype none
// tb_tim_time_base: scoreboard bench; expected update events are queued at stimulus
// time and a negedge monitor pops one per uev_o pulse.
module tb_tim_time_base;

  logic        clk_i = 1'b0;
  logic        aresetn_i;
  logic        cen_i, udis_i, urs_i, arpe_i, dir_cfg_i, opm_i, ug_i, cnt_wr_i;
  logic [1:0]  cms_i;
  logic [15:0] psc_i;
  logic [31:0] arr_i, cnt_wdata_i;
  logic [31:0] cnt_o;
  logic        dir_o, uev_o, uif_set_o, cen_clr_o;

  tim_time_base #(.CNT_WIDTH(32), .PSC_WIDTH(16)) dut (
    .clk_i(clk_i), .aresetn_i(aresetn_i), .cen_i(cen_i), .udis_i(udis_i),
    .urs_i(urs_i), .arpe_i(arpe_i), .dir_cfg_i(dir_cfg_i), .cms_i(cms_i),
    .opm_i(opm_i), .psc_i(psc_i), .arr_i(arr_i), .ug_i(ug_i),
    .cnt_wr_i(cnt_wr_i), .cnt_wdata_i(cnt_wdata_i), .cnt_o(cnt_o),
    .dir_o(dir_o), .uev_o(uev_o), .uif_set_o(uif_set_o), .cen_clr_o(cen_clr_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] cnt;
    logic        dir;
    logic        uif;
    logic        cclr;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] c, input logic d, input logic u, input logic cc);
    exp_t e;
    e.cnt = c; e.dir = d; e.uif = u; e.cclr = cc;
    sb_q.push_back(e);
  endtask

  always @(negedge clk_i) begin
    if (aresetn_i === 1'b1) begin
      if (uev_o) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_uev: got cnt=%0h expected no event at %0t", cnt_o, $time);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("uev_cnt", cnt_o, e.cnt);
          check("uev_dir", 32'(dir_o), 32'(e.dir));
          check("uev_uif", 32'(uif_set_o), 32'(e.uif));
          check("uev_cen_clr", 32'(cen_clr_o), 32'(e.cclr));
        end
      end else if (uif_set_o) begin
        checks++;
        errors++;
        $display("FAIL uif_without_uev: got uif=1 expected 0 at %0t", $time);
      end
    end
  end

  task automatic wait_uev(input int bound, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk_i);
      cyc++;
    end while (!uev_o && cyc < bound);
    if (!uev_o) begin
      checks++;
      errors++;
      $display("FAIL uev_timeout: got none expected uev within %0d cycles", bound);
    end
  endtask

  task automatic pulse_ug();
    ug_i = 1'b1;
    @(negedge clk_i);
    ug_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int n;
    aresetn_i = 1'b0; cen_i = 1'b0; udis_i = 1'b0; urs_i = 1'b0; arpe_i = 1'b1;
    dir_cfg_i = 1'b0; opm_i = 1'b0; ug_i = 1'b0; cnt_wr_i = 1'b0; cms_i = 2'b00;
    psc_i = 16'd2; arr_i = 32'd3; cnt_wdata_i = '0;

    // Reset state
    repeat (2) @(negedge clk_i);
    check("rst_cnt", cnt_o, 32'd0);
    check("rst_dir", 32'(dir_o), 32'd0);
    check("rst_uev", 32'(uev_o), 32'd0);
    check("rst_uif", 32'(uif_set_o), 32'd0);
    check("rst_cen_clr", 32'(cen_clr_o), 32'd0);

    // psc=2 arr=3 edge up: overflow every 12 cycles
    repeat (3) push(32'd0, 1'b0, 1'b1, 1'b0);
    aresetn_i = 1'b1;
    cen_i = 1'b1;
    wait_uev(40, cyc); check("up_first_period", 32'(cyc), 32'd12);
    repeat (3) @(negedge clk_i);
    check("up_cnt_after_tick", cnt_o, 32'd1);
    wait_uev(40, cyc); check("up_rest_period", 32'(cyc), 32'd9);
    wait_uev(40, cyc); check("up_period", 32'(cyc), 32'd12);
    cen_i = 1'b0;

    // Center-aligned psc=0 arr=4
    psc_i = 16'd0; arr_i = 32'd4; cms_i = 2'b01;
    push(32'd0, 1'b0, 1'b1, 1'b0);
    pulse_ug();
    push(32'd3, 1'b1, 1'b1, 1'b0);
    push(32'd1, 1'b0, 1'b1, 1'b0);
    push(32'd3, 1'b1, 1'b1, 1'b0);
    cen_i = 1'b1;
    wait_uev(20, cyc); check("ctr_first", 32'(cyc), 32'd5);
    wait_uev(20, cyc); check("ctr_half1", 32'(cyc), 32'd4);
    wait_uev(20, cyc); check("ctr_half2", 32'(cyc), 32'd4);
    cen_i = 1'b0;

    // arr=0: held at 0 with an event every tick
    cms_i = 2'b00; arr_i = 32'd0;
    push(32'd0, 1'b0, 1'b1, 1'b0);
    pulse_ug();
    repeat (3) push(32'd0, 1'b0, 1'b1, 1'b0);
    cen_i = 1'b1;
    repeat (3) @(negedge clk_i);
    cen_i = 1'b0;
    check("arr0_cnt", cnt_o, 32'd0);

    // Preload on: arr change waits for the next event
    arr_i = 32'd3;
    push(32'd0, 1'b0, 1'b1, 1'b0);
    pulse_ug();
    push(32'd0, 1'b0, 1'b1, 1'b0);
    push(32'd0, 1'b0, 1'b1, 1'b0);
    cen_i = 1'b1;
    @(negedge clk_i);
    arr_i = 32'd7;
    wait_uev(20, cyc); check("arpe1_old_arr", 32'(cyc), 32'd3);
    wait_uev(20, cyc); check("arpe1_new_arr", 32'(cyc), 32'd8);
    cen_i = 1'b0;

    // Preload off: arr change takes effect immediately
    arpe_i = 1'b0; arr_i = 32'd3;
    push(32'd0, 1'b0, 1'b1, 1'b0);
    pulse_ug();
    push(32'd0, 1'b0, 1'b1, 1'b0);
    cen_i = 1'b1;
    @(negedge clk_i);
    arr_i = 32'd7;
    wait_uev(20, cyc); check("arpe0_new_arr", 32'(cyc), 32'd7);
    cen_i = 1'b0;

    // urs hides the ug flag; udis blocks overflow events
    urs_i = 1'b1;
    push(32'd0, 1'b0, 1'b0, 1'b0);
    pulse_ug();
    check("urs_ug_cnt", cnt_o, 32'd0);
    urs_i = 1'b0; udis_i = 1'b1; arr_i = 32'd2;
    cen_i = 1'b1;
    n = 0;
    repeat (7) begin
      @(negedge clk_i);
      if (uev_o) n++;
    end
    cen_i = 1'b0;
    udis_i = 1'b0;
    check("udis_no_uev", 32'(n), 32'd0);

    // ug beats cnt_wr; cnt_wr alone loads silently; cen=0 freezes
    push(32'd0, 1'b0, 1'b1, 1'b0);
    cnt_wdata_i = 32'h55; ug_i = 1'b1; cnt_wr_i = 1'b1;
    @(negedge clk_i);
    ug_i = 1'b0; cnt_wr_i = 1'b0;
    check("ug_over_wr_cnt", cnt_o, 32'd0);
    cnt_wr_i = 1'b1;
    @(negedge clk_i);
    cnt_wr_i = 1'b0;
    check("wr_cnt", cnt_o, 32'h55);
    check("wr_no_uev", 32'(uev_o), 32'd0);
    repeat (3) @(negedge clk_i);
    check("freeze_cnt", cnt_o, 32'h55);

    // Write above arr: run to the natural wrap
    arr_i = 32'd3; cnt_wdata_i = 32'hFFFF_FFFE; cnt_wr_i = 1'b1;
    @(negedge clk_i);
    cnt_wr_i = 1'b0;
    check("wr_big_cnt", cnt_o, 32'hFFFF_FFFE);
    push(32'd0, 1'b0, 1'b1, 1'b0);
    cen_i = 1'b1;
    @(negedge clk_i);
    check("big_cnt_max", cnt_o, 32'hFFFF_FFFF);
    @(negedge clk_i);
    cen_i = 1'b0;
    check("big_cnt_wrap", cnt_o, 32'd0);

    // Edge-aligned down arr=5
    dir_cfg_i = 1'b1; arr_i = 32'd5;
    push(32'd5, 1'b1, 1'b1, 1'b0);
    pulse_ug();
    push(32'd5, 1'b1, 1'b1, 1'b0);
    cen_i = 1'b1;
    wait_uev(20, cyc); check("down_period", 32'(cyc), 32'd6);
    cen_i = 1'b0;
    check("down_dir", 32'(dir_o), 32'd1);
    dir_cfg_i = 1'b0;

    // Reset mid-count
    psc_i = 16'd3;
    push(32'd0, 1'b0, 1'b1, 1'b0);
    pulse_ug();
    cen_i = 1'b1;
    repeat (5) @(negedge clk_i);
    check("pre_rst_cnt", cnt_o, 32'd1);
    #2 aresetn_i = 1'b0;
    #1;
    check("async_rst_cnt", cnt_o, 32'd0);
    check("async_rst_uev", 32'(uev_o), 32'd0);
    @(negedge clk_i);
    aresetn_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("post_rst_no_tick", cnt_o, 32'd0);
    @(negedge clk_i);
    check("post_rst_first_tick", cnt_o, 32'd1);
    cen_i = 1'b0;

`ifdef TIM_OPM_EN
    // One-pulse: single underflow then stop until cen seen low
    psc_i = 16'd0; arr_i = 32'd2; dir_cfg_i = 1'b1; opm_i = 1'b1;
    push(32'd2, 1'b1, 1'b1, 1'b0);
    pulse_ug();
    push(32'd2, 1'b1, 1'b1, 1'b1);
    cen_i = 1'b1;
    wait_uev(20, cyc); check("opm_period", 32'(cyc), 32'd3);
    repeat (3) @(negedge clk_i);
    check("opm_frozen", cnt_o, 32'd2);
    cen_i = 1'b0;
    @(negedge clk_i);
    cen_i = 1'b1;
    @(negedge clk_i);
    check("opm_restart", cnt_o, 32'd1);
    cen_i = 1'b0; opm_i = 1'b0; dir_cfg_i = 1'b0;
`endif

    repeat (2) @(negedge clk_i);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
